// File: rtl/dmem_pkg.sv
// Shared constants and encodings for the data memory arbiter.
// Widths, port indices and the lock-owner encoding.
package dmem_pkg;

  localparam int AW = 6;
  localparam int DW = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    OWN_P0   = 2'd0,
    OWN_P1   = 2'd1,
    OWN_NONE = 2'd2
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with bus lock and lock timeout.
// Ports: clk, reset (sync), req[1:0], lock[1:0] in; gnt[1:0] out.
module rr_arbiter2
  import dmem_pkg::*;
#(
  parameter int MAX_LOCK = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  output logic [1:0] gnt
);

  localparam logic [7:0] MAX_L = 8'(MAX_LOCK);

  logic       last_q, last_d;
  owner_e     owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;

  logic   own_idx;
  logic   lock_hit;
  logic   win;
  owner_e win_own;

  assign own_idx = (owner_q == OWN_P1);

  // Lock only honoured while the count is below the limit;
  // at the limit the owner competes as a plain requester.
  assign lock_hit = (owner_q != OWN_NONE)
                  && req[own_idx]
                  && (cnt_q < MAX_L);

  always_comb begin
    gnt = 2'b00;
    if (reset) begin
      gnt = 2'b00;
    end else if (lock_hit) begin
      gnt = own_idx ? 2'b10 : 2'b01;
    end else if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  assign win     = gnt[1];
  assign win_own = win ? OWN_P1 : OWN_P0;

  always_comb begin
    last_d  = last_q;
    owner_d = OWN_NONE;
    cnt_d   = 8'd0;
    if (gnt != 2'b00) begin
      last_d = win;
      if (lock[win]) begin
        owner_d = win_own;
        // Restart at 1 after a timeout re-grant.
        if (owner_q == win_own && cnt_q < MAX_L)
          cnt_d = cnt_q + 8'd1;
        else
          cnt_d = 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q  <= PORT1;
      owner_q <= OWN_NONE;
      cnt_q   <= 8'd0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between CPU (port 0) and DMA (port 1).
// Ports: reqN/weN/lockN/addrN/wdN in, gntN/rvalidN/rdataN out, mem_* pins.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = dmem_pkg::AW,
  parameter int DW       = dmem_pkg::DW,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  logic [1:0] gnt_v;

  rr_arbiter2 #(
    .MAX_LOCK(MAX_LOCK)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req  ({req1, req0}),
    .lock ({lock1, lock0}),
    .gnt  (gnt_v)
  );

  assign gnt0 = gnt_v[0];
  assign gnt1 = gnt_v[1];

  // Port 0 drives the bus whenever port 1 is not granted.
  assign mem_addr = gnt1 ? addr1 : addr0;
  assign mem_wd   = gnt1 ? wd1 : wd0;
  assign mem_we   = (gnt0 & we0) | (gnt1 & we1);

  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  always_comb begin
    rvalid0_d = gnt0 & ~we0;
    rvalid1_d = gnt1 & ~we1;
    rdata0_d  = rvalid0_d ? mem_rd : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rd : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 64x32 memory.
// Ports: none; drives all DUT inputs and checks outputs.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1;
  logic        we0, we1;
  logic        lock0, lock1;
  logic [5:0]  addr0, addr1;
  logic [31:0] wd0, wd1;
  logic        gnt0, gnt1;
  logic        rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];

  int n_tests;
  int n_fail;
  int j;

  data_mem_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .we0     (we0),
    .we1     (we1),
    .lock0   (lock0),
    .lock1   (lock1),
    .addr0   (addr0),
    .addr1   (addr1),
    .wd0     (wd0),
    .wd1     (wd1),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .rvalid0 (rvalid0),
    .rvalid1 (rvalid1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .mem_we  (mem_we),
    .mem_addr(mem_addr),
    .mem_wd  (mem_wd),
    .mem_rd  (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wd;
  end

  function automatic logic [31:0] exp_mem(input int a);
    if (a == 5) return 32'hDEADBEEF;
    return 32'hA000_0000 | 32'(a);
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++)
      mem[i] = 32'hA000_0000 | 32'(i);
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    lock0 = 0; lock1 = 0;
    addr0 = 0; addr1 = 0; wd0 = 0; wd1 = 0;
    tick();
    tick();

    // reset state, with requests asserted
    req0 = 1; req1 = 1; we0 = 1;
    #1;
    check("rst_gnt0", 32'(gnt0), 0);
    check("rst_gnt1", 32'(gnt1), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_rv0", 32'(rvalid0), 0);
    check("rst_rv1", 32'(rvalid1), 0);
    check("rst_rd0", rdata0, 0);
    check("rst_rd1", rdata1, 0);
    req0 = 0; req1 = 0; we0 = 0;
    reset = 0;

    // single write then read on port 0
    req0 = 1; we0 = 1; addr0 = 6'd5; wd0 = 32'hDEADBEEF;
    #1;
    check("wr_gnt0", 32'(gnt0), 1);
    check("wr_we", 32'(mem_we), 1);
    check("wr_addr", 32'(mem_addr), 5);
    check("wr_wd", mem_wd, 32'hDEADBEEF);
    tick();
    we0 = 0;
    #1;
    check("rd_gnt0", 32'(gnt0), 1);
    check("rd_we", 32'(mem_we), 0);
    check("wr_norv", 32'(rvalid0), 0);
    tick();
    req0 = 0;
    #1;
    check("rd_rv0", 32'(rvalid0), 1);
    check("rd_data0", rdata0, 32'hDEADBEEF);

    // round-robin contention after reset
    reset = 1;
    tick();
    reset = 0;
    req0 = 1; req1 = 1; addr0 = 6'd10; addr1 = 6'd20;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_gnt0", 32'(gnt0), (i % 2 == 0) ? 1 : 0);
      check("rr_gnt1", 32'(gnt1), (i % 2 == 1) ? 1 : 0);
      check("rr_addr", 32'(mem_addr), (i % 2 == 0) ? 10 : 20);
      tick();
      check("rr_rv0", 32'(rvalid0), (i % 2 == 0) ? 1 : 0);
      check("rr_rv1", 32'(rvalid1), (i % 2 == 1) ? 1 : 0);
      if (i % 2 == 0) check("rr_rd0", rdata0, exp_mem(10));
      else            check("rr_rd1", rdata1, exp_mem(20));
    end
    req0 = 0; req1 = 0;
    tick();

    // locked burst on port 1 with timeout
    j = 0;
    req1 = 1; lock1 = 1; we1 = 0; addr0 = 6'd33;
    for (int c = 0; c < 13; c++) begin
      req0  = (c >= 1);
      addr1 = 6'(j);
      #1;
      check("lk_gnt1", 32'(gnt1), (c != 8) ? 1 : 0);
      check("lk_gnt0", 32'(gnt0), (c == 8) ? 1 : 0);
      tick();
      if (c != 8) begin
        check("lk_rv1", 32'(rvalid1), 1);
        check("lk_rd1", rdata1, exp_mem(j));
        j++;
      end else begin
        check("lk_rv1_off", 32'(rvalid1), 0);
        check("lk_rv0", 32'(rvalid0), 1);
        check("lk_rd0", rdata0, exp_mem(33));
      end
      if (c == 7) check("lk_cnt_max", 32'(dut.u_arb.cnt_q), 8);
    end
    check("lk_words", 32'(j), 12);
    req0 = 0; req1 = 0; lock1 = 0;
    tick();

    // early lock release by port 0; loser lock ignored
    req0 = 1; lock0 = 1; addr0 = 6'd3;
    req1 = 1; lock1 = 1; addr1 = 6'd40;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) begin
        lock0 = 0;
        lock1 = 0;
      end
      #1;
      check("rl_gnt0", 32'(gnt0), 1);
      check("rl_gnt1", 32'(gnt1), 0);
      tick();
      if (c == 2) check("rl_cnt3", 32'(dut.u_arb.cnt_q), 3);
    end
    check("rl_cnt0", 32'(dut.u_arb.cnt_q), 0);
    #1;
    check("rl_next1", 32'(gnt1), 1);
    check("rl_next0", 32'(gnt0), 0);
    tick();
    check("rl_rv1", 32'(rvalid1), 1);
    check("rl_rd1", rdata1, exp_mem(40));
    req0 = 0; req1 = 0;
    tick();

    // reset in the third cycle of a locked port 1 burst
    req1 = 1; lock1 = 1; addr1 = 6'd0;
    #1;
    check("rb_gnt1a", 32'(gnt1), 1);
    tick();
    addr1 = 6'd1;
    #1;
    check("rb_gnt1b", 32'(gnt1), 1);
    tick();
    check("rb_rv1b", 32'(rvalid1), 1);
    check("rb_rd1b", rdata1, exp_mem(1));
    addr1 = 6'd2;
    reset = 1;
    #1;
    check("rb_gnt0", 32'(gnt0), 0);
    check("rb_gnt1", 32'(gnt1), 0);
    tick();
    check("rb_rv1", 32'(rvalid1), 0);
    check("rb_rd1", rdata1, 0);
    check("rb_cnt", 32'(dut.u_arb.cnt_q), 0);
    reset = 0; lock1 = 0;
    req0 = 1; addr0 = 6'd7;
    #1;
    check("rb_tie0", 32'(gnt0), 1);
    check("rb_tie1", 32'(gnt1), 0);
    tick();
    check("rb_rv0", 32'(rvalid0), 1);
    check("rb_rd0", rdata0, exp_mem(7));

    // idle: nothing granted, data held
    req0 = 0; req1 = 0; we0 = 1; we1 = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("id_we", 32'(mem_we), 0);
      check("id_gnt", {30'd0, gnt1, gnt0}, 0);
      tick();
      check("id_rv", {30'd0, rvalid1, rvalid0}, 0);
      check("id_rd0", rdata0, exp_mem(7));
      check("id_rd1", rdata1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
